axi_slave_txn_ctrl: RTL and testbench
=====================================

Name: axi_slave_txn_ctrl

Overview:
- Transaction sequencer between the PS general-purpose AXI master and the fabric register/buffer space of the E1 receiver.
- Accepts AXI write and read bursts, arbitrates AW against AR round-robin, and converts each beat into single-word accesses on a simple memory port.
- Generates the R/B channel responses with the request ID echoed.
- One transaction in flight at a time.

Parameters:
ID_W, 12, AXI ID width
DATA_W, 32, data width; beats are always DATA_W/8 bytes
LEN_W, 8, burst length field width
MEM_AW, 10, word-address width of the memory port; window is 2^MEM_AW words

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
s_awvalid/s_awready  in/out  1  AW handshake
s_awaddr  in  32  write byte address
s_awlen  in  LEN_W  beats-1
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_awid  in  ID_W  write ID
s_wvalid/s_wready  in/out  1  W handshake
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte strobes
s_wlast  in  1  last write beat
s_bvalid/s_bready  out/in  1  B handshake
s_bid  out  ID_W  echoed AWID
s_bresp  out  2  00 OKAY, 10 SLVERR
s_arvalid/s_arready  in/out  1  AR handshake
s_araddr, s_arlen, s_arburst, s_arid  in  32/LEN_W/2/ID_W  read request
s_rvalid/s_rready  out/in  1  R handshake
s_rdata  out  DATA_W  read data
s_rid  out  ID_W  echoed ARID
s_rresp  out  2  00 OKAY, 10 SLVERR
s_rlast  out  1  last read beat
mem_req  out  1  one-cycle access strobe
mem_we  out  1  1 = write
mem_addr  out  MEM_AW  word address
mem_wdata  out  DATA_W  write data
mem_wstrb  out  DATA_W/8  byte enables
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after read mem_req

Behaviour:
- Reset: state IDLE. All valid/ready outputs, mem_req and mem_we are 0. ID, resp and data registers are 0. Round-robin pointer last_rd=1, so a write wins the first tie.
- States: IDLE, WDATA, WRESP, RREQ, RWAIT, RDATA.
- IDLE arbitration:
  - s_awready = IDLE & s_awvalid & (!s_arvalid | last_rd).
  - s_arready = IDLE & s_arvalid & (!s_awvalid | !last_rd).
  - At most one is high per cycle.
  - On grant: latch addr[MEM_AW+1:2], len, burst and id; clear beat counter and error flag; set last_rd to the granted direction.
- Error condition: burst==WRAP or burst==11 sets err. When err is set, no mem_req is issued for the whole burst; beats are still consumed or produced, with rdata=0 and resp=SLVERR.
- Address update after each beat:
  - INCR: addr+1, modulo 2^MEM_AW (wraps inside the window).
  - FIXED: address unchanged.
  - Upper address bits are ignored, so the window aliases.
- WDATA:
  - s_wready=1.
  - On each wvalid&wready: mem_req=!err, mem_we=1, mem_wdata/mem_wstrb driven straight from W in the same cycle; counter increments.
  - The burst terminates on the beat where counter==len, independent of s_wlast.
  - If s_wlast disagrees with counter==len on any beat, err is set (bresp SLVERR). Data already written stays written.
- WRESP:
  - Entered the cycle after the final beat; s_bvalid=1, s_bid=latched id, s_bresp from err.
  - Held stable until s_bready, then IDLE.
  - bvalid is never asserted in the same cycle as the last W beat.
- Read path, one beat at a time:
  - RREQ: mem_req=!err, mem_we=0.
  - RWAIT: mem_rdata captured into the rdata register (0 when err).
  - RDATA: s_rvalid=1, s_rlast=(counter==len), rid and rresp driven. Held stable until s_rready. Then either go to RREQ for the next beat or, on the last beat, to IDLE.
  - Latency: AR handshake at cycle N, mem_req at N+1, rvalid at N+3 for the first beat.
  - Per-beat throughput is 3 cycles when rready is held high.
- Simultaneous events:
  - AW and AR in the same cycle are resolved by the pointer. The loser stays pending and is granted on the first IDLE cycle after the current transaction completes.
  - No request is accepted outside IDLE.
- Back-pressure: with wvalid=0 or rready=0 the FSM stalls indefinitely and all outputs stay stable.
- Reset mid-burst: returns to IDLE next cycle with outputs at their reset values. No partial response is produced and the counter is cleared.

Test Plan:
- INCR write awaddr=0x40, awlen=3, data 0xA0..0xA3, wstrb=F -> mem writes at word addr 0x10..0x13; bvalid one cycle after beat 4; bid=awid; bresp=00.
- INCR read araddr=0x40, arlen=3, rready=1 -> mem_req at N+1, first rvalid at N+3; rdata 0xA0..0xA3; rlast only on beat 4; rid=arid.
- AW and AR asserted together in 3 consecutive rounds from reset -> grants in order W, R, W; the loser's valid stays high and is accepted right after the preceding response handshake.
- FIXED read arlen=2 at word 0x3FF, then INCR write at 0xFFC with awlen=1 -> all read beats at addr 0x3FF; write beats at 0x3FF then 0x000.
- WRAP write awlen=1 -> no mem_req, bresp=10. Separately, an INCR write with awlen=1 and wlast on beat 1 -> both beats written, bresp=10.
- Reset asserted during RDATA with rready=0 -> next cycle rvalid=0, state IDLE; a new AR afterwards completes normally with rresp=00.

Source files
------------

// File: rtl/axi_slave_txn_ctrl.sv
// rtl/axi_slave_txn_ctrl.sv - AXI burst slave sequencing single-word accesses onto a memory port
module axi_slave_txn_ctrl #(
  parameter int ID_W   = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int MEM_AW = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_awaddr,
  input  logic [LEN_W-1:0]    s_awlen,
  input  logic [1:0]          s_awburst,
  input  logic [ID_W-1:0]     s_awid,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [31:0]         s_araddr,
  input  logic [LEN_W-1:0]    s_arlen,
  input  logic [1:0]          s_arburst,
  input  logic [ID_W-1:0]     s_arid,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [ID_W-1:0]     s_rid,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREQ, RWAIT, RDATA} state_t;

  state_t              state;
  logic [MEM_AW-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [1:0]          burst_q;
  logic [ID_W-1:0]     id_q;
  logic                burst_err;
  logic                last_err;
  logic                last_rd;
  logic [DATA_W-1:0]   rdata_q;

  logic                aw_win;
  logic                ar_win;
  logic                w_beat;
  logic                last_beat;
  logic [MEM_AW-1:0]   addr_next;
  logic                unused_addr_bits;

  assign aw_win    = s_awvalid & (~s_arvalid | last_rd);
  assign ar_win    = s_arvalid & (~s_awvalid | ~last_rd);
  assign s_awready = (state == IDLE) & aw_win;
  assign s_arready = (state == IDLE) & ar_win;

  assign w_beat    = (state == WDATA) & s_wvalid;
  assign last_beat = (cnt_q == len_q);
  // FIXED keeps the address; INCR rolls over inside the 2^MEM_AW word window
  assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + MEM_AW'(1);

  assign s_wready  = (state == WDATA);
  assign s_bvalid  = (state == WRESP);
  assign s_bid     = id_q;
  assign s_bresp   = {burst_err | last_err, 1'b0};
  assign s_rvalid  = (state == RDATA);
  assign s_rdata   = rdata_q;
  assign s_rid     = id_q;
  assign s_rresp   = {burst_err, 1'b0};
  assign s_rlast   = (state == RDATA) & last_beat;

  assign mem_req   = (w_beat | (state == RREQ)) & ~burst_err;
  assign mem_we    = w_beat & ~burst_err;
  assign mem_addr  = addr_q;
  assign mem_wdata = s_wdata;
  assign mem_wstrb = s_wstrb;

  assign unused_addr_bits = ^{s_awaddr[31:MEM_AW+2], s_awaddr[1:0],
                              s_araddr[31:MEM_AW+2], s_araddr[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      id_q      <= '0;
      burst_err <= 1'b0;
      last_err  <= 1'b0;
      last_rd   <= 1'b1;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_win) begin
            addr_q    <= s_awaddr[MEM_AW+1:2];
            len_q     <= s_awlen;
            burst_q   <= s_awburst;
            id_q      <= s_awid;
            cnt_q     <= '0;
            burst_err <= s_awburst[1];
            last_err  <= 1'b0;
            last_rd   <= 1'b0;
            state     <= WDATA;
          end else if (ar_win) begin
            addr_q    <= s_araddr[MEM_AW+1:2];
            len_q     <= s_arlen;
            burst_q   <= s_arburst;
            id_q      <= s_arid;
            cnt_q     <= '0;
            burst_err <= s_arburst[1];
            last_err  <= 1'b0;
            last_rd   <= 1'b1;
            state     <= RREQ;
          end
        end
        WDATA: begin
          if (s_wvalid) begin
            // Beat count alone ends the burst; a disagreeing wlast only flags the response
            if (s_wlast != last_beat) last_err <= 1'b1;
            if (last_beat) begin
              state <= WRESP;
            end else begin
              cnt_q  <= cnt_q + LEN_W'(1);
              addr_q <= addr_next;
            end
          end
        end
        WRESP: begin
          if (s_bready) state <= IDLE;
        end
        RREQ: begin
          state <= RWAIT;
        end
        RWAIT: begin
          rdata_q <= burst_err ? '0 : mem_rdata;
          state   <= RDATA;
        end
        RDATA: begin
          if (s_rready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              cnt_q  <= cnt_q + LEN_W'(1);
              addr_q <= addr_next;
              state  <= RREQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_txn_ctrl.sv
// tb/tb_axi_slave_txn_ctrl.sv - randomized self-checking bench for axi_slave_txn_ctrl
module tb_axi_slave_txn_ctrl;
  localparam int LIM = 40;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        s_awvalid = 1'b0, s_awready;
  logic [31:0] s_awaddr = '0;
  logic [7:0]  s_awlen = '0;
  logic [1:0]  s_awburst = '0;
  logic [11:0] s_awid = '0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0;
  logic        s_bvalid, s_bready = 1'b0;
  logic [11:0] s_bid;
  logic [1:0]  s_bresp;
  logic        s_arvalid = 1'b0, s_arready;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [1:0]  s_arburst = '0;
  logic [11:0] s_arid = '0;
  logic        s_rvalid, s_rready = 1'b0;
  logic [31:0] s_rdata;
  logic [11:0] s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  axi_slave_txn_ctrl dut (
    .CLK(CLK), .RST(RST),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awburst(s_awburst), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] env_mem [1024];
  logic [31:0] ref_mem [1024];
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  bit          rd_hit = 0;
  logic [9:0]  rd_addr = '0;
  bit          directed = 0;

  logic [31:0] aw_a, ar_a;
  int          aw_len, ar_len;
  logic [1:0]  aw_b, ar_b;
  logic [11:0] aw_id, ar_id;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic we, input logic [9:0] a,
                                       input logic [31:0] d, input logic [3:0] s);
    return {17'b0, we, a, d, s};
  endfunction

  // Memory environment: applies observed writes, answers reads one cycle after the request
  always @(negedge CLK) begin
    if (!RST && mem_req) begin
      obs_q.push_back(pack(mem_we, mem_addr, mem_we ? mem_wdata : 32'h0, mem_we ? mem_wstrb : 4'h0));
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) env_mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        rd_hit  = 1;
        rd_addr = mem_addr;
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rd_hit) begin
      mem_rdata = env_mem[rd_addr];
      rd_hit    = 0;
    end else begin
      mem_rdata = $urandom;
    end
  end

  task automatic set_aw(input logic [31:0] a, input int len, input logic [1:0] b, input logic [11:0] id);
    aw_a = a; aw_len = len; aw_b = b; aw_id = id;
    s_awaddr = a; s_awlen = 8'(len); s_awburst = b; s_awid = id; s_awvalid = 1'b1;
  endtask

  task automatic set_ar(input logic [31:0] a, input int len, input logic [1:0] b, input logic [11:0] id);
    ar_a = a; ar_len = len; ar_b = b; ar_id = id;
    s_araddr = a; s_arlen = 8'(len); s_arburst = b; s_arid = id; s_arvalid = 1'b1;
  endtask

  task automatic compare_mem(input string tag);
    check({tag, "_nacc"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check({tag, "_acc"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_write(input int bad, output int wt);
    int          n;
    int          k;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  st;
    logic        berr;
    logic        werr;
    logic [1:0]  eresp;
    n = 0;
    @(negedge CLK);
    while (!s_awready && n < LIM) begin n++; @(negedge CLK); end
    wt = n;
    check("aw_hs", s_awready, 1);
    check("aw_ar_excl", s_arready, 0);
    @(posedge CLK); #1;
    s_awvalid = 1'b0;
    berr = aw_b[1];
    werr = 0;
    a = aw_a[11:2];
    for (int i = 0; i <= aw_len; i++) begin
      k = $urandom_range(0, 2);
      repeat (k) begin @(posedge CLK); #1; end
      d  = directed ? 32'hA0 + 32'(i) : $urandom;
      st = directed ? 4'hF : 4'($urandom_range(1, 15));
      s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
      s_wlast = (i == aw_len) ^ (i == bad);
      if (i == bad) werr = 1;
      n = 0;
      @(negedge CLK);
      while (!s_wready && n < LIM) begin n++; @(negedge CLK); end
      check("w_hs", s_wready, 1);
      if (i == aw_len) check("bvalid_early", s_bvalid, 0);
      if (!berr) begin
        exp_q.push_back(pack(1'b1, a, d, st));
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end
      if (aw_b != 2'b00) a = a + 10'd1;
      @(posedge CLK); #1;
      s_wvalid = 1'b0; s_wlast = 1'b0;
    end
    eresp = (berr || werr) ? 2'b10 : 2'b00;
    @(negedge CLK);
    check("bvalid", s_bvalid, 1);
    check("bid", s_bid, aw_id);
    check("bresp", s_bresp, eresp);
    k = $urandom_range(0, 3);
    repeat (k) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check("b_hold", {s_bvalid, s_bid, s_bresp}, {1'b1, aw_id, eresp});
    end
    s_bready = 1'b1;
    @(posedge CLK); #1;
    s_bready = 1'b0;
    compare_mem("wr");
  endtask

  task automatic run_read(output int wt);
    int          n;
    int          k;
    logic [9:0]  a;
    logic        berr;
    logic [31:0] ed;
    logic [1:0]  eresp;
    n = 0;
    @(negedge CLK);
    while (!s_arready && n < LIM) begin n++; @(negedge CLK); end
    wt = n;
    check("ar_hs", s_arready, 1);
    check("ar_aw_excl", s_awready, 0);
    @(posedge CLK); #1;
    s_arvalid = 1'b0;
    berr  = ar_b[1];
    eresp = berr ? 2'b10 : 2'b00;
    a = ar_a[11:2];
    for (int i = 0; i <= ar_len; i++) begin
      @(negedge CLK);
      check("rd_req", mem_req, !berr);
      check("rvalid_lat1", s_rvalid, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      check("rvalid_lat2", s_rvalid, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      ed = berr ? 32'h0 : ref_mem[a];
      check("rvalid", s_rvalid, 1);
      check("rdata", s_rdata, ed);
      check("rlast", s_rlast, (i == ar_len));
      check("rid", s_rid, ar_id);
      check("rresp", s_rresp, eresp);
      if (!berr) exp_q.push_back(pack(1'b0, a, 32'h0, 4'h0));
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(posedge CLK); #1;
        @(negedge CLK);
        check("r_hold", {s_rvalid, s_rdata, s_rlast, s_rid, s_rresp},
              {1'b1, ed, (i == ar_len), ar_id, eresp});
      end
      s_rready = 1'b1;
      @(posedge CLK); #1;
      s_rready = 1'b0;
      if (ar_b != 2'b00) a = a + 10'd1;
    end
    compare_mem("rd");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    int n;
    int len;
    int r;
    int bad;
    logic [1:0] b;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end

    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("rst_outs", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, mem_req, mem_we}, 8'h00);
    check("rst_regs", {s_bid, s_rid, s_bresp, s_rresp, s_rdata}, 64'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Three arbitration rounds from reset: W, then R, then W
    directed = 1;
    set_aw(32'h40, 3, 2'b01, 12'h3A1);
    set_ar(32'h40, 3, 2'b01, 12'h7C2);
    run_write(-1, wt);
    check("arb_r1_wait", wt, 0);
    directed = 0;
    set_aw(32'h200, 2, 2'b01, 12'h155);
    run_read(wt);
    check("arb_r2_wait", wt, 0);
    run_write(-1, wt);
    check("arb_r3_wait", wt, 0);

    // FIXED read at the top word, then INCR write wrapping out of the window
    set_ar(32'hFFC, 2, 2'b00, 12'h011);
    run_read(wt);
    set_aw(32'hFFC, 1, 2'b01, 12'h022);
    run_write(-1, wt);
    set_ar(32'h7654_3FFC, 1, 2'b01, 12'h033);
    run_read(wt);

    // Error bursts
    set_aw(32'h80, 1, 2'b10, 12'h044);
    run_write(-1, wt);
    set_aw(32'h90, 1, 2'b01, 12'h055);
    run_write(0, wt);
    set_ar(32'h90, 1, 2'b01, 12'h066);
    run_read(wt);
    set_ar(32'hA0, 2, 2'b11, 12'h077);
    run_read(wt);

    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 5);
      r = $urandom_range(0, 9);
      b = (r < 4) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 1) == 1) begin
        bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
        set_aw($urandom, len, b, 12'($urandom));
        run_write(bad, wt);
      end else begin
        set_ar($urandom, len, b, 12'($urandom));
        run_read(wt);
      end
    end

    // Reset while a read beat waits in RDATA with rready low
    set_ar(32'h100, 1, 2'b01, 12'h5A5);
    n = 0;
    @(negedge CLK);
    while (!s_arready && n < LIM) begin n++; @(negedge CLK); end
    check("rst_ar_hs", s_arready, 1);
    @(posedge CLK); #1;
    s_arvalid = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    @(negedge CLK);
    check("rst_pre_rvalid", s_rvalid, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_rvalid", s_rvalid, 0);
    check("rst_mid_misc", {mem_req, s_bvalid, s_rdata, s_rid}, 64'h0);
    obs_q.delete();
    exp_q.delete();
    @(posedge CLK); #1;
    set_ar(32'h100, 1, 2'b01, 12'h5A6);
    run_read(wt);
    check("rst_after_wait", wt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
